mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the processor's single-port system memory between three requesters: instruction fetch (port 0), load/store unit (port 1), and debug/IO loader (port 2).
- Round-robin arbitration with one outstanding transaction at a time.
- Issues registered commands to the memory and routes fixed-latency read data back to the winning port.
- Sits between the core and the memory block inside `system`.

Parameters:
- ADDR_W, 16, address width per port and memory side
- DATA_W, 16, data width
- MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to valid mem_rdata (legal range 1..7)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous active-low reset; 0 resets, 1 runs
- req  in  3  per-port request; held high with stable we/addr/wdata until gnt
- we  in  3  per-port write enable; 1 = write, 0 = read
- addr  in  3*ADDR_W  packed addresses; port i at [i*ADDR_W +: ADDR_W]
- wdata  in  3*DATA_W  packed write data; port i at [i*DATA_W +: DATA_W]
- gnt  out  3  one-hot, one-cycle grant pulse
- rvalid  out  3  one-hot, one-cycle read-data-valid pulse
- rdata  out  DATA_W  read data; continuous passthrough of mem_rdata, qualified by rvalid
- mem_en  out  1  memory command strobe
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:

Reset (rst=0, asynchronous):
- state = IDLE; gnt = 0, rvalid = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, busy = 0.
- Round-robin pointer last = 2, so port 0 has highest priority first.
- Wait counter = 0.
- Reset during ISSUE or WAIT aborts the transaction: no rvalid is ever produced for it.

Arbitration:
- req is sampled only in IDLE.
- Search order is last+1, last+2, last+3 (mod 3); the first asserted req wins.
- At the edge that leaves IDLE, register winner index, we, addr and wdata, and set last = winner.
- With no req asserted, remain in IDLE and leave last unchanged.

FSM:
- IDLE -> ISSUE when any req is asserted.
- ISSUE, exactly one cycle:
  - mem_en = 1; mem_we, mem_addr and mem_wdata carry the latched values.
  - gnt[winner] = 1.
  - Next state: write -> IDLE; read -> WAIT with counter = MEM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - In the cycle where counter = 1, mem_rdata is valid: rvalid[winner] = 1 and rdata = mem_rdata.
  - Next state is IDLE.

Cycle timing (cycle 0 = IDLE cycle in which req is sampled):
- Read: gnt in cycle 1; rvalid in cycle 1+MEM_LAT; back in IDLE at cycle 2+MEM_LAT.
- Write: gnt in cycle 1; back in IDLE at cycle 2.
- Peak throughput: one write per 2 cycles, one read per 2+MEM_LAT cycles.

Requester rule:
- A requester drops req (or presents its next request) in the cycle after gnt.
- A req still high in IDLE after its grant is treated as a new request.

Boundary rules:
- Simultaneous requests are resolved by round-robin only. No port waits more than 2 other grants.
- A request that arrives while busy waits; it is never dropped.
- gnt and rvalid are never asserted together for different ports.
- mem_en is high only in ISSUE.
- we, addr and wdata changes after the IDLE sampling edge are ignored.
- rdata is don't-care when no rvalid bit is set.

Test Plan:
1. Reset check: hold rst=0 with req=3'b111. All outputs stay 0. Release rst: first grant goes to port 0, then port 1, then port 2, then port 0.
2. Single read, MEM_LAT=1: port 1 reads addr 0x0040, memory returns 0xBEEF. Required response: gnt=3'b010 in cycle 1 with mem_en=1, mem_we=0, mem_addr=0x0040; rvalid=3'b010 with rdata=0xBEEF in cycle 2; busy low in cycle 3.
3. Write: port 2 writes 0x1234 to 0x00FF. Required response: cycle 1 shows mem_en=1, mem_we=1, mem_addr=0x00FF, mem_wdata=0x1234, gnt=3'b100. No rvalid is produced. IDLE in cycle 2.
4. Fairness: ports 0 and 1 request continuously for 10 transactions. Grants strictly alternate 0,1,0,1,… and port 2 is never granted.
5. MEM_LAT=3 read: rvalid arrives exactly in cycle 4 and the next grant appears in cycle 6. Run a back-to-back write immediately after and confirm no overlap.
6. Reset mid-read: assert rst=0 during WAIT, then release. No rvalid appears and the pending req is regranted after reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between three requesters.
// Runs one transaction at a time: registered command issue, fixed-latency read return.
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
   output logic [2:0]            gnt,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   localparam logic [2:0] LAT_C = 3'(MEM_LAT);

   state_t              state_r;
   state_t              state_next_s;
   logic [1:0]          last_r;
   logic [1:0]          win_r;
   logic [1:0]          win_s;
   logic                we_r;
   logic [2:0]          cnt_r;
   logic                issue_next_s;
   logic [2:0]          rvalid_next_s;
   logic [2:0]          gnt_r;
   logic [2:0]          rvalid_r;
   logic                mem_en_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [DATA_W-1:0]   mem_wdata_r;
   logic                busy_r;

   // Search starts just after the last winner and wraps around the three ports.
   function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] l);
      logic [1:0] p0;
      logic [1:0] p1;
      logic [1:0] p2;
      case (l)
         2'd0: begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
         2'd1: begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
         default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
      endcase
      if (r[p0]) begin
         rr_pick = p0;
      end else if (r[p1]) begin
         rr_pick = p1;
      end else begin
         rr_pick = p2;
      end
   endfunction

   function automatic logic [2:0] one_hot(input logic [1:0] idx);
      one_hot = 3'b001 << idx;
   endfunction

   // Winner selection and next-state decode.
   always_comb begin
      win_s         = rr_pick(req, last_r);
      issue_next_s  = 1'b0;
      rvalid_next_s = 3'b000;
      state_next_s  = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req != 3'b000) begin
               issue_next_s = 1'b1;
               state_next_s = ST_ISSUE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (we_r) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT;
               if (LAT_C == 3'd1) begin
                  rvalid_next_s = one_hot(win_r);
               end else begin
                  rvalid_next_s = 3'b000;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_r == 3'd1) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_WAIT;
               if (cnt_r == 3'd2) begin
                  rvalid_next_s = one_hot(win_r);
               end else begin
                  rvalid_next_s = 3'b000;
               end
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 3'd0;
      end else begin
         state_r <= state_next_s;
         if (state_r == ST_ISSUE) begin
            cnt_r <= LAT_C;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - 3'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Transaction capture and registered memory/requester outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_r      <= 2'd2;
         win_r       <= 2'd0;
         we_r        <= 1'b0;
         gnt_r       <= 3'b000;
         rvalid_r    <= 3'b000;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         busy_r      <= 1'b0;
      end else begin
         rvalid_r <= rvalid_next_s;
         mem_en_r <= issue_next_s;
         busy_r   <= (state_next_s != ST_IDLE);
         if (issue_next_s) begin
            win_r       <= win_s;
            last_r      <= win_s;
            we_r        <= we[win_s];
            gnt_r       <= one_hot(win_s);
            mem_we_r    <= we[win_s];
            mem_addr_r  <= addr[win_s*ADDR_W +: ADDR_W];
            mem_wdata_r <= wdata[win_s*DATA_W +: DATA_W];
         end else begin
            gnt_r    <= 3'b000;
            mem_we_r <= 1'b0;
         end
      end
   end

   assign gnt       = gnt_r;
   assign rvalid    = rvalid_r;
   assign rdata     = mem_rdata;
   assign mem_en    = mem_en_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and 3) against a transaction-level
// schedule model, a behavioural memory, directed scenarios and randomized traffic.
module tb_mem_port_arbiter;

   typedef struct {
      logic [2:0]  gnt;
      logic [2:0]  rvalid;
      logic        en;
      logic        we;
      logic        busy;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } rec_t;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } txn_t;

   typedef struct {
      int          c;
      int          p;
      logic        we;
      logic [15:0] a;
      logic [15:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_v       [2];
   logic [2:0]  req_v       [2];
   logic [2:0]  we_v        [2];
   logic [47:0] addr_v      [2];
   logic [47:0] wdata_v     [2];
   logic [2:0]  gnt_v       [2];
   logic [2:0]  rvalid_v    [2];
   logic [15:0] rdata_v     [2];
   logic        mem_en_v    [2];
   logic        mem_we_v    [2];
   logic [15:0] mem_addr_v  [2];
   logic [15:0] mem_wdata_v [2];
   logic [15:0] mem_rdata_v [2];
   logic        busy_v      [2];

   int   lat [2] = '{1, 3};
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   gap_en = 1'b0;

   rec_t        sched_q [2][$];
   txn_t        pq      [2][3][$];
   ev_t         glog    [2][$];
   ev_t         rlog    [2][$];
   int          dly     [2][3];
   int          last_p  [2];
   logic [15:0] env_mem [2][16];
   logic [15:0] mdl_mem [2][16];
   logic        rd_pend [2];
   int          rd_cyc  [2];
   logic [15:0] rd_dat  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT((g == 0) ? 1 : 3)) u_dut (
         .clk       (clk),
         .rst       (rst_v[g]),
         .req       (req_v[g]),
         .we        (we_v[g]),
         .addr      (addr_v[g]),
         .wdata     (wdata_v[g]),
         .gnt       (gnt_v[g]),
         .rvalid    (rvalid_v[g]),
         .rdata     (rdata_v[g]),
         .mem_en    (mem_en_v[g]),
         .mem_we    (mem_we_v[g]),
         .mem_addr  (mem_addr_v[g]),
         .mem_wdata (mem_wdata_v[g]),
         .mem_rdata (mem_rdata_v[g]),
         .busy      (busy_v[g])
      );
   end

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, expv);
      end
   endtask

   function automatic int oh2i(input logic [2:0] v);
      if (v[1]) return 1;
      else if (v[2]) return 2;
      else return 0;
   endfunction

   // Build the whole expected cycle sequence of one transaction when the DUT is idle.
   task automatic schedule(input int k);
      rec_t r;
      int   w;
      w = -1;
      for (int i = 1; i <= 3; i++) begin
         if (w < 0 && req_v[k][(last_p[k] + i) % 3]) w = (last_p[k] + i) % 3;
      end
      if (w >= 0) begin
         last_p[k] = w;
         r = '{gnt: 3'(1 << w), rvalid: 3'b000, en: 1'b1, we: we_v[k][w], busy: 1'b1,
               addr: addr_v[k][w*16 +: 16], wdata: wdata_v[k][w*16 +: 16], rdata: 16'h0000};
         sched_q[k].push_back(r);
         if (r.we) begin
            mdl_mem[k][r.addr[3:0]] = r.wdata;
         end else begin
            for (int i = 1; i <= lat[k]; i++) begin
               rec_t q;
               q = '{gnt: 3'b000, rvalid: (i == lat[k]) ? 3'(1 << w) : 3'b000, en: 1'b0, we: 1'b0,
                     busy: 1'b1, addr: r.addr, wdata: 16'h0000, rdata: mdl_mem[k][r.addr[3:0]]};
               sched_q[k].push_back(q);
            end
         end
      end
   endtask

   task automatic drive_req(input int k);
      for (int p = 0; p < 3; p++) begin
         if (pq[k][p].size() > 0 && dly[k][p] == 0) begin
            req_v[k][p]           = 1'b1;
            we_v[k][p]            = pq[k][p][0].we;
            addr_v[k][p*16 +: 16] = pq[k][p][0].addr;
            wdata_v[k][p*16 +: 16] = pq[k][p][0].wdata;
         end else begin
            req_v[k][p]           = 1'b0;
            we_v[k][p]            = 1'($urandom);
            addr_v[k][p*16 +: 16] = 16'($urandom);
            wdata_v[k][p*16 +: 16] = 16'($urandom);
         end
      end
   endtask

   task automatic step(input int k);
      rec_t e;
      ev_t  ev;
      if (sched_q[k].size() > 0) e = sched_q[k].pop_front();
      else e = '{gnt: 3'b000, rvalid: 3'b000, en: 1'b0, we: 1'b0, busy: 1'b0,
                 addr: 16'h0000, wdata: 16'h0000, rdata: 16'h0000};
      chk("gnt", k, 16'(gnt_v[k]), 16'(e.gnt));
      chk("rvalid", k, 16'(rvalid_v[k]), 16'(e.rvalid));
      chk("mem_en", k, 16'(mem_en_v[k]), 16'(e.en));
      chk("busy", k, 16'(busy_v[k]), 16'(e.busy));
      if (e.en) begin
         chk("mem_we", k, 16'(mem_we_v[k]), 16'(e.we));
         chk("mem_addr", k, mem_addr_v[k], e.addr);
         if (e.we) chk("mem_wdata", k, mem_wdata_v[k], e.wdata);
         ev = '{c: cyc, p: oh2i(e.gnt), we: e.we, a: e.addr, d: e.wdata};
         glog[k].push_back(ev);
      end
      if (e.rvalid != 3'b000) begin
         chk("rdata", k, rdata_v[k], e.rdata);
         ev = '{c: cyc, p: oh2i(e.rvalid), we: 1'b0, a: e.addr, d: e.rdata};
         rlog[k].push_back(ev);
      end
      // behavioural memory follows whatever command the DUT actually issues
      if (mem_en_v[k] === 1'b1) begin
         if (mem_we_v[k]) begin
            env_mem[k][mem_addr_v[k][3:0]] = mem_wdata_v[k];
         end else begin
            rd_pend[k] = 1'b1;
            rd_cyc[k]  = cyc;
            rd_dat[k]  = env_mem[k][mem_addr_v[k][3:0]];
         end
      end
      if (rd_pend[k] && rd_cyc[k] + lat[k] == cyc + 1) begin
         mem_rdata_v[k] = rd_dat[k];
         rd_pend[k]     = 1'b0;
      end else begin
         mem_rdata_v[k] = 16'($urandom);
      end
      for (int p = 0; p < 3; p++) begin
         if (e.gnt[p]) begin
            void'(pq[k][p].pop_front());
            dly[k][p] = gap_en ? $urandom_range(0, 3) : 0;
         end else if (dly[k][p] > 0) begin
            dly[k][p]--;
         end
      end
      drive_req(k);
      if (rst_v[k] && !e.busy) schedule(k);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) step(k);
   endtask

   task automatic do_reset(input int k, input logic val);
      rst_v[k] = val;
      if (!val) begin
         sched_q[k].delete();
         last_p[k]  = 2;
         rd_pend[k] = 1'b0;
      end else begin
         schedule(k);
      end
   endtask

   task automatic enq(input int k, input int p, input logic w, input logic [15:0] a, input logic [15:0] d);
      txn_t t;
      t = '{we: w, addr: a, wdata: d};
      pq[k][p].push_back(t);
   endtask

   function automatic bit quiet();
      bit q;
      q = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (sched_q[k].size() > 0) q = 1'b0;
         for (int p = 0; p < 3; p++) if (pq[k][p].size() > 0) q = 1'b0;
      end
      return q;
   endfunction

   task automatic run_quiet(input int budget);
      int n;
      n = 0;
      while (!quiet() && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (!quiet()) begin
         failures++;
         $display("FAIL timeout cyc=%0d got=busy want=idle within %0d cycles", cyc, budget);
      end
      tick();
   endtask

   task automatic clear_logs();
      for (int k = 0; k < 2; k++) begin
         glog[k].delete();
         rlog[k].delete();
      end
   endtask

   initial begin
      int mark;
      int rel;
      int exp_p [4] = '{0, 1, 2, 0};
      for (int k = 0; k < 2; k++) begin
         rst_v[k] = 1'b0;
         req_v[k] = 3'b000;
         we_v[k] = 3'b000;
         addr_v[k] = 48'h0;
         wdata_v[k] = 48'h0;
         mem_rdata_v[k] = 16'h0;
         last_p[k] = 2;
         rd_pend[k] = 1'b0;
         rd_cyc[k] = 0;
         rd_dat[k] = 16'h0;
         for (int p = 0; p < 3; p++) dly[k][p] = 0;
         for (int i = 0; i < 16; i++) begin
            env_mem[k][i] = 16'(i * 16'h0101);
            mdl_mem[k][i] = 16'(i * 16'h0101);
         end
      end

      // reset held with all ports requesting, then release
      for (int k = 0; k < 2; k++) begin
         enq(k, 0, 1'b1, 16'h0010, 16'h1111);
         enq(k, 1, 1'b1, 16'h0021, 16'h2222);
         enq(k, 2, 1'b1, 16'h0032, 16'h3333);
         enq(k, 0, 1'b1, 16'h0043, 16'h4444);
      end
      repeat (3) tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_mem_we", k, 16'(mem_we_v[k]), 16'h0000);
         chk("rst_mem_addr", k, mem_addr_v[k], 16'h0000);
         chk("rst_mem_wdata", k, mem_wdata_v[k], 16'h0000);
      end
      clear_logs();
      rel = cyc;
      do_reset(0, 1'b1);
      do_reset(1, 1'b1);
      run_quiet(200);
      for (int k = 0; k < 2; k++) begin
         chk("rst_gnt_count", k, 16'(glog[k].size()), 16'd4);
         for (int i = 0; i < glog[k].size() && i < 4; i++) begin
            chk("rst_gnt_port", k, 16'(glog[k][i].p), 16'(exp_p[i]));
            chk("rst_gnt_cyc", k, 16'(glog[k][i].c - rel), 16'(1 + 2 * i));
         end
      end

      // single read on port 1, MEM_LAT=1
      env_mem[0][0] = 16'hBEEF;
      mdl_mem[0][0] = 16'hBEEF;
      clear_logs();
      mark = cyc + 1;
      enq(0, 1, 1'b0, 16'h0040, 16'h0000);
      run_quiet(50);
      chk("rd_gnt_count", 0, 16'(glog[0].size()), 16'd1);
      chk("rd_rv_count", 0, 16'(rlog[0].size()), 16'd1);
      if (glog[0].size() > 0) begin
         chk("rd_gnt_cyc", 0, 16'(glog[0][0].c - mark), 16'd1);
         chk("rd_gnt_port", 0, 16'(glog[0][0].p), 16'd1);
         chk("rd_addr", 0, glog[0][0].a, 16'h0040);
      end
      if (rlog[0].size() > 0) begin
         chk("rd_rv_cyc", 0, 16'(rlog[0][0].c - mark), 16'd2);
         chk("rd_rdata", 0, rlog[0][0].d, 16'hBEEF);
      end

      // single write on port 2
      clear_logs();
      mark = cyc + 1;
      enq(0, 2, 1'b1, 16'h00FF, 16'h1234);
      run_quiet(50);
      chk("wr_gnt_count", 0, 16'(glog[0].size()), 16'd1);
      chk("wr_rv_count", 0, 16'(rlog[0].size()), 16'd0);
      if (glog[0].size() > 0) begin
         chk("wr_gnt_cyc", 0, 16'(glog[0][0].c - mark), 16'd1);
         chk("wr_gnt_port", 0, 16'(glog[0][0].p), 16'd2);
         chk("wr_we", 0, 16'(glog[0][0].we), 16'd1);
         chk("wr_addr", 0, glog[0][0].a, 16'h00FF);
         chk("wr_wdata", 0, glog[0][0].d, 16'h1234);
      end

      // fairness between two continuously requesting ports
      clear_logs();
      for (int i = 0; i < 5; i++) begin
         enq(0, 0, 1'(i % 2), 16'(16'h0100 + i), 16'(16'hA000 + i));
         enq(0, 1, 1'((i + 1) % 2), 16'(16'h0200 + i), 16'(16'hB000 + i));
      end
      run_quiet(200);
      chk("fair_count", 0, 16'(glog[0].size()), 16'd10);
      for (int i = 0; i < glog[0].size(); i++) begin
         chk("fair_port", 0, 16'(glog[0][i].p), 16'(i % 2));
      end

      // MEM_LAT=3 read followed by a write that arrives while busy
      env_mem[1][3] = 16'hA5A5;
      mdl_mem[1][3] = 16'hA5A5;
      clear_logs();
      mark = cyc + 1;
      enq(1, 0, 1'b0, 16'h0123, 16'h0000);
      tick();
      enq(1, 1, 1'b1, 16'h0456, 16'h5A5A);
      run_quiet(50);
      chk("lat3_gnt_count", 1, 16'(glog[1].size()), 16'd2);
      chk("lat3_rv_count", 1, 16'(rlog[1].size()), 16'd1);
      if (glog[1].size() > 1) begin
         chk("lat3_gnt0_cyc", 1, 16'(glog[1][0].c - mark), 16'd1);
         chk("lat3_gnt1_cyc", 1, 16'(glog[1][1].c - mark), 16'd6);
         chk("lat3_gnt1_port", 1, 16'(glog[1][1].p), 16'd1);
      end
      if (rlog[1].size() > 0) begin
         chk("lat3_rv_cyc", 1, 16'(rlog[1][0].c - mark), 16'd4);
         chk("lat3_rdata", 1, rlog[1][0].d, 16'hA5A5);
      end

      // reset during WAIT aborts the read; the re-presented request is served afterwards
      clear_logs();
      mark = cyc + 1;
      enq(1, 1, 1'b0, 16'h0077, 16'h0000);
      repeat (3) tick();
      do_reset(1, 1'b0);
      enq(1, 1, 1'b0, 16'h0077, 16'h0000);
      repeat (2) tick();
      chk("abort_rv_count", 1, 16'(rlog[1].size()), 16'd0);
      rel = cyc;
      do_reset(1, 1'b1);
      run_quiet(50);
      chk("abort_gnt_count", 1, 16'(glog[1].size()), 16'd2);
      chk("abort_rv_total", 1, 16'(rlog[1].size()), 16'd1);
      if (glog[1].size() > 1) begin
         chk("abort_gnt0_cyc", 1, 16'(glog[1][0].c - mark), 16'd1);
         chk("abort_regnt_cyc", 1, 16'(glog[1][1].c - rel), 16'd1);
         chk("abort_regnt_port", 1, 16'(glog[1][1].p), 16'd1);
      end
      if (rlog[1].size() > 0) begin
         chk("abort_rv_cyc", 1, 16'(rlog[1][0].c - rel), 16'd4);
      end

      // randomized traffic on both instances
      gap_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 60; i++) begin
               enq(k, p, 1'($urandom), 16'($urandom), 16'($urandom));
            end
         end
      end
      run_quiet(5000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
